mmcm_reset_sequencer: RTL and testbench

- Sits directly downstream of the MMCM clock generator and is clocked by its buffered output clock.
- Synchronises the asynchronous MMCM LOCKED flag and qualifies it as stable for a programmable number of cycles.
- Then releases a vector of per-domain active-low resets one stage at a time, with a fixed gap between stages, before flagging the core as READY.
- Any loss of lock or soft-reset request re-asserts every stage reset and restarts the sequence.

---
 rtl/mmcm_reset_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mmcm_reset_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mmcm_reset_sequencer.sv
// mmcm_reset_sequencer: qualifies MMCM LOCKED, then releases staged resets.
// Optional lock-loss event counter enabled by defining LOCK_LOSS_CNT_EN.
module mmcm_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int NUM_STAGES         = 4,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int CNT_W              = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  LOCKED,
  input  logic                  SOFT_RESET,
  output logic [NUM_STAGES-1:0] STAGE_RESET_N,
  output logic                  READY,
  output logic [1:0]            SEQ_STATE
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [CNT_W-1:0]      LOCK_LOSS_COUNT
`endif
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable
    $error("LOCK_STABLE_CYCLES must be >= 1");
  end
  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
    $error("NUM_STAGES must be 1..8");
  end
  if (STAGE_GAP_CYCLES < 1) begin : g_bad_gap
    $error("STAGE_GAP_CYCLES must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be >= 1");
  end

  localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int GW = $clog2(STAGE_GAP_CYCLES) + 1;
  localparam int IW = $clog2(NUM_STAGES) + 1;

  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    HOLD        = 2'd0,
    WAIT_STABLE = 2'd1,
    RELEASE     = 2'd2,
    RUN         = 2'd3
  } state_t;

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;
  logic                   lock_all;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) lock_sync <= '0;
    else        lock_sync <= {lock_sync[SYNC_STAGES-2:0], LOCKED};
  end

  assign lock_s   = lock_sync[SYNC_STAGES-1];
  // Any low flop in the chain means a loss is on its way: freeze releases.
  assign lock_all = &lock_sync;

  state_t                state_q, state_d;
  logic [SW-1:0]         stab_q, stab_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ready_q, ready_d;
  logic                  loss;
  logic                  abort;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      stab_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ready_d = ready_q;
    loss    = (state_q != HOLD) && !lock_s;
    abort   = (state_q != HOLD) && (!lock_s || SOFT_RESET);
    if (abort) begin
      state_d = HOLD;
      stab_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      stage_d = '0;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          stab_d  = '0;
          gap_d   = '0;
          idx_d   = '0;
          stage_d = '0;
          ready_d = 1'b0;
          if (lock_s) state_d = WAIT_STABLE;
        end
        WAIT_STABLE: begin
          if (stab_q != STABLE_LAST) begin
            stab_d = stab_q + 1'b1;
          end else if (lock_all) begin
            state_d = RELEASE;
            stage_d = NUM_STAGES'(1);
            idx_d   = '0;
            gap_d   = '0;
          end
        end
        RELEASE: begin
          if (gap_q != GAP_LAST) begin
            gap_d = gap_q + 1'b1;
          end else if (lock_all) begin
            gap_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              // Released bits are contiguous from bit 0; extend by one.
              stage_d = stage_q | (stage_q << 1);
            end
          end
        end
        RUN: begin
          stage_d = '1;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  assign STAGE_RESET_N = stage_q;
  assign READY         = ready_q;
  assign SEQ_STATE     = state_q;

`ifdef LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] llc_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      llc_q <= '0;
    end else if (loss && (llc_q != '1)) begin
      llc_q <= llc_q + 1'b1;
    end
  end

  assign LOCK_LOSS_COUNT = llc_q;
`endif

endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// tb_mmcm_reset_sequencer: directed vector table plus corner sequences.
// Lock-loss counter checks compile in when LOCK_LOSS_CNT_EN is defined.
module tb_mmcm_reset_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       LOCKED;
  logic       SOFT_RESET;
  logic [2:0] STAGE_RESET_N;
  logic       READY;
  logic [1:0] SEQ_STATE;
`ifdef LOCK_LOSS_CNT_EN
  logic [1:0] LOCK_LOSS_COUNT;
`endif

  int errors = 0;
  int checks = 0;

  mmcm_reset_sequencer #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .NUM_STAGES        (3),
    .STAGE_GAP_CYCLES  (4),
    .CNT_W             (2)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .LOCKED       (LOCKED),
    .SOFT_RESET   (SOFT_RESET),
    .STAGE_RESET_N(STAGE_RESET_N),
    .READY        (READY),
    .SEQ_STATE    (SEQ_STATE)
`ifdef LOCK_LOSS_CNT_EN
    ,
    .LOCK_LOSS_COUNT(LOCK_LOSS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       lk;
    logic       sr;
    int         n;
    logic [2:0] stg;
    logic       rdy;
    logic [1:0] st;
    int         llc;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic lk, input logic sr, input int n,
                     input logic [2:0] stg, input logic rdy,
                     input logic [1:0] st, input int llc);
    vec_t v;
    v.lk  = lk;
    v.sr  = sr;
    v.n   = n;
    v.stg = stg;
    v.rdy = rdy;
    v.st  = st;
    v.llc = llc;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int s0;
    int rd;

    // bring-up, edges counted from E0
    add(1, 0, 1, 3'b000, 0, 0, 0);
    add(1, 0, 2, 3'b000, 0, 1, 0);
    add(1, 0, 7, 3'b000, 0, 1, 0);
    add(1, 0, 1, 3'b001, 0, 2, 0);
    add(1, 0, 3, 3'b001, 0, 2, 0);
    add(1, 0, 1, 3'b011, 0, 2, 0);
    add(1, 0, 3, 3'b011, 0, 2, 0);
    add(1, 0, 1, 3'b111, 0, 2, 0);
    add(1, 0, 3, 3'b111, 0, 2, 0);
    add(1, 0, 1, 3'b111, 1, 3, 0);
    add(1, 0, 8, 3'b111, 1, 3, 0);
    // soft reset in RUN
    add(1, 1, 1, 3'b000, 0, 0, 0);
    add(1, 0, 1, 3'b000, 0, 1, 0);
    add(1, 0, 7, 3'b000, 0, 1, 0);
    add(1, 0, 1, 3'b001, 0, 2, 0);
    add(1, 0, 4, 3'b011, 0, 2, 0);
    // lock loss mid-release
    add(0, 0, 1, 3'b011, 0, 2, 0);
    add(0, 0, 1, 3'b011, 0, 2, 0);
    add(0, 0, 1, 3'b000, 0, 0, 1);
    add(0, 0, 6, 3'b000, 0, 0, 1);
    // short lock glitch
    add(1, 0, 5, 3'b000, 0, 1, 1);
    add(0, 0, 1, 3'b000, 0, 1, 1);
    add(0, 0, 1, 3'b000, 0, 1, 1);
    add(0, 0, 1, 3'b000, 0, 0, 2);
    add(0, 0, 10, 3'b000, 0, 0, 2);
    // soft reset ignored in HOLD
    add(0, 1, 1, 3'b000, 0, 0, 2);
    add(0, 0, 1, 3'b000, 0, 0, 2);

    RESET_N    = 1'b1;
    LOCKED     = 1'b0;
    SOFT_RESET = 1'b0;
    #1 RESET_N = 1'b0;
    #1;
    chk("rst stage", 32'(STAGE_RESET_N), 32'd0);
    chk("rst ready", 32'(READY), 32'd0);
    chk("rst state", 32'(SEQ_STATE), 32'd0);
    repeat (2) tick();
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) tick();

    foreach (tv[i]) begin
      LOCKED     = tv[i].lk;
      SOFT_RESET = tv[i].sr;
      repeat (tv[i].n) begin
        tick();
        SOFT_RESET = 1'b0;
      end
      chk($sformatf("v%0d stage", i), 32'(STAGE_RESET_N), 32'(tv[i].stg));
      chk($sformatf("v%0d ready", i), 32'(READY), 32'(tv[i].rdy));
      chk($sformatf("v%0d state", i), 32'(SEQ_STATE), 32'(tv[i].st));
`ifdef LOCK_LOSS_CNT_EN
      chk($sformatf("v%0d llc", i), 32'(LOCK_LOSS_COUNT), 32'(tv[i].llc));
`endif
    end

    // three more lock losses from WAIT_STABLE: counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      LOCKED = 1'b1;
      repeat (4) tick();
      chk($sformatf("sat%0d wait", k), 32'(SEQ_STATE), 32'd1);
      LOCKED = 1'b0;
      repeat (4) tick();
      chk($sformatf("sat%0d hold", k), 32'(SEQ_STATE), 32'd0);
      chk($sformatf("sat%0d stage", k), 32'(STAGE_RESET_N), 32'd0);
`ifdef LOCK_LOSS_CNT_EN
      chk($sformatf("sat%0d llc", k), 32'(LOCK_LOSS_COUNT), 32'd3);
`endif
    end

    // async reset in RUN, then full re-sequence
    LOCKED = 1'b1;
    repeat (30) tick();
    chk("run state", 32'(SEQ_STATE), 32'd3);
    chk("run stage", 32'(STAGE_RESET_N), 32'h7);
    chk("run ready", 32'(READY), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst stage", 32'(STAGE_RESET_N), 32'd0);
    chk("arst ready", 32'(READY), 32'd0);
    chk("arst state", 32'(SEQ_STATE), 32'd0);
`ifdef LOCK_LOSS_CNT_EN
    chk("arst llc", 32'(LOCK_LOSS_COUNT), 32'd0);
`endif
    @(negedge CLK);
    RESET_N = 1'b1;
    s0 = -1;
    rd = -1;
    for (int i = 0; i < 60 && rd < 0; i++) begin
      tick();
      if (s0 < 0 && STAGE_RESET_N[0]) s0 = i;
      if (READY) rd = i;
    end
    chk("rerun bit0 edge", 32'(s0), 32'd12);
    chk("rerun ready edge", 32'(rd), 32'd24);
    chk("rerun state", 32'(SEQ_STATE), 32'd3);
    chk("rerun stage", 32'(STAGE_RESET_N), 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
